irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Prioritising interrupt controller directly upstream of the multi-cycle control unit.
- Synchronises external device interrupt lines and latches their rising edges as pending bits, then applies a software mask and the CPSR I bit.
- Presents one request at a time to the control unit through an int_req/int_ack handshake, together with a vector address and source id.
- Tracks in-service sources so that only higher-priority interrupts can nest, and retires the active source on end-of-interrupt. The control unit signals end-of-interrupt on MOVS PC return.

Parameters:
- N_SRC, 8, number of interrupt sources; index 0 is the highest priority.
- VEC_BASE, 32'h0000_0100, vector address of source 0.
- VEC_STRIDE, 4, byte spacing between consecutive source vectors.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- irq_in  input  N_SRC  raw device interrupt lines, asynchronous, level.
- mask_we  input  1  one-cycle write strobe for the enable mask.
- mask_wdata  input  N_SRC  new enable mask; 1 = source enabled.
- cpsr_i  input  1  CPSR interrupt-disable bit; 1 blocks new requests.
- int_ack  input  1  one-cycle pulse from the control unit when it enters interrupt entry.
- eoi  input  1  one-cycle pulse from the control unit on MOVS PC return.
- int_req  output  1  interrupt request to the control unit.
- int_id  output  clog2(N_SRC)  id of the requested source.
- int_vec  output  32  VEC_BASE + int_id*VEC_STRIDE.
- pending  output  N_SRC  latched pending bits.
- in_service  output  N_SRC  in-service bits.
- mask  output  N_SRC  current enable mask.

Behaviour:
- Reset (async) clears all registers, the state, and both synchroniser stages:
  - int_req=0, int_id=0, int_vec=VEC_BASE, pending=0, in_service=0, mask=0.
- Synchroniser: each irq_in bit passes through a 2-FF synchroniser, then an edge detector (previous-sample register).
- Pending: pending[k] sets on the cycle after a synchronised rising edge of source k.
  - Latency: an irq_in edge set up before clk edge E1 gives pending[k]=1 after clk edge E3.
  - Level-held lines do not re-pend.
- Mask: on mask_we, mask <= mask_wdata at the clock edge. Masking never clears pending; it only blocks selection.
- Candidate: the lowest index k with pending[k] & mask[k].
  - The candidate is eligible only if cpsr_i==0 and in_service has no set bit at index <= k.
  - Only strictly higher priority may preempt.
- FSM, 2 states:
  - IDLE: int_req=0. If an eligible candidate exists, register int_id=k and int_vec, then go to REQ. int_req=1 from the next cycle.
  - REQ: int_req=1; int_id and int_vec stay frozen.
    - On int_ack: clear pending[int_id], set in_service[int_id], go to IDLE. int_req=0 next cycle.
    - Without int_ack: if cpsr_i rises, or mask[int_id] clears, withdraw by going to IDLE with int_req=0. pending is retained.
  - A higher-priority source becoming eligible while in REQ does not change int_id. It is re-evaluated after the ack or withdraw.
- eoi: clears the lowest-index set bit of in_service. If in_service==0, eoi is ignored. eoi is accepted in either state.
- Minimum gap: after an ack, IDLE takes one cycle to re-evaluate before a new int_req.
- Simultaneous events:
  - Edge on k in the same cycle as an ack of k: pending[k] stays 1, because the new edge wins over the clear.
  - int_ack in IDLE: ignored.
  - eoi and ack in the same cycle: the eoi clear (lowest set bit of the pre-update in_service) and the ack set both apply.
  - mask_we together with a withdraw condition: use the registered mask, so the withdraw happens next cycle.
- rst mid-REQ: int_req drops immediately (asynchronously); all pending and in-service state is lost.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding IC_IDLE/IC_REQ.
  - N_SRC default.
  - VEC_BASE/VEC_STRIDE constants.
  - clog2-based id width.
- One natural sub-module: irq_sync_edge, the per-bit 2-FF synchroniser plus rising-edge detector, instantiated N_SRC-wide.
- The priority encoder and the FSM stay in the top level.

Test Plan:
- Basic request:
  - Stimulus: reset; mask=8'hFF; cpsr_i=0; raise irq_in[3].
  - Required: pending=8'h08 three edges later; int_req=1 one cycle after that with int_id=3 and int_vec=32'h10C.
  - Then pulse int_ack: int_req=0 next cycle, pending=0, in_service=8'h08.
- Priority and nesting:
  - Stimulus: in_service=8'h08; irq 5 and irq 1 edges arrive together.
  - Required: int_id=1 requested, ack gives in_service=8'h0A; irq 5 is not requested.
  - First eoi gives in_service=8'h08; second eoi gives 8'h00, then int_id=5 is requested.
- Masking and cpsr_i:
  - Stimulus: mask=8'h00 with pending irq 2.
  - Required: no int_req, and pending stays 8'h04.
  - Set mask[2]=1 with cpsr_i=1: still no int_req. Drop cpsr_i: int_req with int_id=2.
- Withdraw: raise cpsr_i while in REQ without ack -> int_req=0 next cycle and pending bit kept; lowering cpsr_i re-requests the same id.
- Edge during ack: new edge on source 4 in the same cycle int_ack retires 4 -> pending[4]=1, in_service[4]=1, and no request is made until eoi.
- Reset mid-REQ: assert rst while int_req=1 -> all outputs equal reset values immediately, without waiting for clk; stray eoi/int_ack afterwards have no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the interrupt controller slice.
//   - IC_IDLE / IC_REQ : request FSM state encoding
//   - IC_N_SRC         : default number of interrupt sources
//   - IC_VEC_BASE      : default vector address of source 0
//   - IC_VEC_STRIDE    : default byte spacing between source vectors
//   - ic_id_w()        : width of a source id for a given source count
package cpu_pkg;

  localparam logic [0:0] IC_IDLE = 1'b0;
  localparam logic [0:0] IC_REQ  = 1'b1;

  localparam int          IC_N_SRC      = 8;
  localparam logic [31:0] IC_VEC_BASE   = 32'h0000_0100;
  localparam int          IC_VEC_STRIDE = 4;

  // A single-source controller still needs a 1-bit id port.
  function automatic int ic_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-FF synchroniser followed by a rising-edge detector.
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears every stage
//   d    : raw asynchronous level input
//   rise : one-cycle pulse when the synchronised level goes 0 -> 1
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      // Metastability stage
      sync_p0 <= d;
      // Synchronised level
      sync_p1 <= sync_p0;
      // Previous synchronised sample for edge detection
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/irq_controller.sv
// Prioritising interrupt controller feeding the multi-cycle control unit.
// Device lines are synchronised, rising edges latch pending bits, a software
// mask and the CPSR I bit gate selection, and one request at a time is
// offered through an int_req/int_ack handshake. Acknowledged sources become
// in-service; only strictly higher-priority sources may nest above them.
// eoi (MOVS PC return) retires the highest-priority in-service source.
//   clk, rst    : clock, asynchronous active-high reset
//   irq_in      : raw device interrupt lines (index 0 = highest priority)
//   mask_we     : write strobe for the enable mask
//   mask_wdata  : new enable mask, 1 = enabled
//   cpsr_i      : CPSR I bit, 1 blocks new requests
//   int_ack     : control unit entered interrupt entry
//   eoi         : end of interrupt
//   int_req     : request to the control unit
//   int_id      : id of the requested source
//   int_vec     : vector address of the requested source
//   pending     : latched pending bits
//   in_service  : in-service bits
//   mask        : current enable mask
module irq_controller
  import cpu_pkg::*;
#(
  parameter int          N_SRC      = IC_N_SRC,
  parameter logic [31:0] VEC_BASE   = IC_VEC_BASE,
  parameter int          VEC_STRIDE = IC_VEC_STRIDE,
  localparam int         ID_W       = ic_id_w(N_SRC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_wdata,
  input  logic              cpsr_i,
  input  logic              int_ack,
  input  logic              eoi,
  output logic              int_req,
  output logic [ID_W-1:0]   int_id,
  output logic [31:0]       int_vec,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  in_service,
  output logic [N_SRC-1:0]  mask
);

  logic [0:0]       state;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_onehot;
  logic [N_SRC-1:0] eoi_clr;
  logic             cand_found;
  logic             cand_blocked;
  logic             svc_seen;
  logic [ID_W-1:0]  cand_id;
  logic [31:0]      cand_vec;
  logic             eligible;
  logic             ack_take;
  logic             withdraw;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (irq_in[g]),
      .rise (rise[g])
    );
  end

  // Lowest-index pending & enabled source. svc_seen accumulates in_service
  // bits up to and including the current index, so cand_blocked is set when
  // an equal-or-higher priority source is already in service.
  always_comb begin
    cand_found   = 1'b0;
    cand_blocked = 1'b0;
    cand_id      = '0;
    svc_seen     = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      svc_seen = svc_seen | in_service[i];
      if (!cand_found && pending[i] && mask[i]) begin
        cand_found   = 1'b1;
        cand_id      = ID_W'(i);
        cand_blocked = svc_seen;
      end
    end
  end

  assign cand_vec = VEC_BASE + 32'(cand_id) * 32'(VEC_STRIDE);
  assign eligible = cand_found & ~cand_blocked & ~cpsr_i;

  // int_ack outside REQ is ignored. The withdraw test uses the registered
  // mask, so a mask write in the same cycle only takes effect a cycle later.
  assign ack_take   = (state == IC_REQ) & int_ack;
  assign withdraw   = (state == IC_REQ) & ~int_ack & (cpsr_i | ~mask[int_id]);
  assign ack_onehot = ack_take ? (N_SRC'(1) << int_id) : '0;

  // x & -x isolates the lowest set bit, i.e. the highest-priority source.
  assign eoi_clr = eoi ? (in_service & (~in_service + N_SRC'(1))) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IC_IDLE;
      int_id     <= '0;
      int_vec    <= VEC_BASE;
      pending    <= '0;
      in_service <= '0;
      mask       <= '0;
    end else begin
      // A fresh edge wins over the acknowledge clear of the same source.
      pending    <= (pending & ~ack_onehot) | rise;
      in_service <= (in_service & ~eoi_clr) | ack_onehot;
      if (mask_we) begin
        mask <= mask_wdata;
      end
      case (state)
        IC_IDLE: begin
          if (eligible) begin
            state   <= IC_REQ;
            int_id  <= cand_id;
            int_vec <= cand_vec;
          end
        end
        default: begin
          // id and vector stay frozen; higher-priority arrivals wait.
          if (ack_take || withdraw) begin
            state <= IC_IDLE;
          end
        end
      endcase
    end
  end

  assign int_req = (state == IC_REQ);

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  localparam int          NS   = 8;
  localparam logic [31:0] VB   = 32'h0000_0100;
  localparam int          VS   = 4;

  logic          clk;
  logic          rst;
  logic [NS-1:0] irq_in;
  logic          mask_we;
  logic [NS-1:0] mask_wdata;
  logic          cpsr_i;
  logic          int_ack;
  logic          eoi;
  logic          int_req;
  logic [2:0]    int_id;
  logic [31:0]   int_vec;
  logic [NS-1:0] pending;
  logic [NS-1:0] in_service;
  logic [NS-1:0] mask;

  irq_controller dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .cpsr_i     (cpsr_i),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .int_id     (int_id),
    .int_vec    (int_vec),
    .pending    (pending),
    .in_service (in_service),
    .mask       (mask)
  );

  typedef struct packed {
    logic          req;
    logic [2:0]    id;
    logic [31:0]   vec;
    logic [NS-1:0] pend;
    logic [NS-1:0] svc;
    logic [NS-1:0] msk;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  // Reference model state: what the controller should hold after each edge.
  bit            m_req;
  int            m_id;
  logic [NS-1:0] m_pend, m_svc, m_mask;
  // Raw line samples taken at the previous three clock edges.
  logic [NS-1:0] h1, h2, h3;

  logic [NS-1:0] cur_irq;
  bit            cur_cpsr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.req = int_req; s.id = int_id; s.vec = int_vec;
    s.pend = pending; s.svc = in_service; s.msk = mask;
    return s;
  endfunction

  task automatic model_reset();
    m_req = 0; m_id = 0; m_pend = '0; m_svc = '0; m_mask = '0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  // Drive one clock's worth of inputs (called at a falling edge), predict the
  // state after the next rising edge, queue it, and move to the next falling edge.
  task automatic cycle(input bit mwe, input logic [NS-1:0] md, input bit ack, input bit eo);
    logic [NS-1:0] edges, n_pend, n_svc;
    bit   n_req;
    int   n_id, k, s;
    snap_t e;
    irq_in = cur_irq; cpsr_i = cur_cpsr; mask_we = mwe; mask_wdata = md;
    int_ack = ack; eoi = eo;

    // A line counts as newly raised when seen high two edges ago but low three edges ago.
    edges = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = cur_irq;

    n_pend = m_pend; n_svc = m_svc; n_req = m_req; n_id = m_id;
    s = lowest(m_svc);
    if (eo && s >= 0) n_svc[s] = 1'b0;
    if (m_req) begin
      if (ack) begin
        n_pend[m_id] = 1'b0;
        n_svc[m_id]  = 1'b1;
        n_req = 0;
      end else if (cur_cpsr || !m_mask[m_id]) begin
        n_req = 0;
      end
    end else begin
      k = lowest(m_pend & m_mask);
      if (k >= 0 && !cur_cpsr && (s < 0 || s > k)) begin
        n_req = 1; n_id = k;
      end
    end
    n_pend = n_pend | edges;

    m_pend = n_pend; m_svc = n_svc; m_req = n_req; m_id = n_id;
    if (mwe) m_mask = md;

    e.req = m_req; e.id = 3'(m_id); e.vec = VB + 32'(m_id * VS);
    e.pend = m_pend; e.svc = m_svc; e.msk = m_mask;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 12 && !m_req; i++) cycle(0, '0, 0, 0);
    checks++;
    if (!m_req) begin
      errors++;
      $display("FAIL %s: no request within 12 cycles, want one", name);
    end
  endtask

  task automatic check_reset(input string name);
    snap_t a, e;
    a = dut_snap();
    e.req = 0; e.id = 3'd0; e.vec = VB; e.pend = '0; e.svc = '0; e.msk = '0;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got req=%0b id=%0d vec=%h pend=%h svc=%h mask=%h, want reset values",
               name, a.req, a.id, a.vec, a.pend, a.svc, a.msk);
    end
  endtask

  // Monitor: every rising edge with a queued prediction is compared.
  always @(posedge clk) begin
    snap_t a, e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_snap();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL state@cyc%0d: got req=%0b id=%0d vec=%h pend=%h svc=%h mask=%h, want req=%0b id=%0d vec=%h pend=%h svc=%h mask=%h",
                 cyc, a.req, a.id, a.vec, a.pend, a.svc, a.msk,
                 e.req, e.id, e.vec, e.pend, e.svc, e.msk);
      end
    end
  end

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 0; mask_wdata = '0;
    cpsr_i = 0; int_ack = 0; eoi = 0;
    cur_irq = '0; cur_cpsr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset_values");
    rst = 1'b0;

    // Basic request on source 3
    cycle(1, 8'hFF, 0, 0);
    cur_irq = 8'h08;
    wait_req("basic_req");
    cycle(0, '0, 1, 0);
    idle(2);

    // Priority and nesting: 1 nests above 3, 5 waits for both eois
    cur_irq = 8'h2A;
    wait_req("nest_req1");
    cycle(0, '0, 1, 0);
    idle(5);
    cycle(0, '0, 0, 1);
    idle(3);
    cycle(0, '0, 0, 1);
    wait_req("req5_after_eoi");
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 1);
    idle(2);

    // Masking and cpsr_i
    cur_irq = 8'h00;
    cycle(1, 8'h00, 0, 0);
    cur_irq = 8'h04;
    idle(6);
    cur_cpsr = 1;
    cycle(1, 8'h04, 0, 0);
    idle(4);
    cur_cpsr = 0;
    wait_req("req2_after_cpsr");

    // Withdraw by cpsr_i, then re-request
    cur_cpsr = 1;
    idle(3);
    cur_cpsr = 0;
    wait_req("rereq2");
    // Withdraw by mask clear coinciding with a mask write
    cycle(1, 8'h00, 0, 0);
    idle(2);
    cycle(1, 8'hFF, 0, 0);
    wait_req("rereq2_mask");
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 1);

    // New edge on source 4 in the same cycle as its acknowledge
    cur_irq = 8'h14;
    wait_req("req4");
    cur_irq = 8'h04; cycle(0, '0, 0, 0);
    cur_irq = 8'h14; cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 1, 0);
    idle(5);
    cycle(0, '0, 0, 1);
    wait_req("req4_again");

    // Asynchronous reset while requesting
    #2 rst = 1'b1;
    #1 check_reset("async_reset_midreq");
    @(negedge clk);
    int_ack = 1; eoi = 1;
    @(negedge clk);
    check_reset("reset_held_stray_ack_eoi");
    rst = 1'b0;
    model_reset();
    cur_irq = '0;
    cycle(0, '0, 1, 1);
    idle(3);

    // Randomised traffic
    cycle(1, 8'hFF, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit mwe, ack, eo;
      logic [NS-1:0] md;
      for (int b = 0; b < NS; b++)
        if ($urandom_range(99) < 8) cur_irq[b] = ~cur_irq[b];
      if ($urandom_range(99) < 6) cur_cpsr = ~cur_cpsr;
      mwe = ($urandom_range(99) < 5);
      md  = NS'($urandom) | NS'($urandom);
      ack = m_req ? ($urandom_range(99) < 40) : ($urandom_range(99) < 5);
      eo  = ($urandom_range(99) < 8);
      cycle(mwe, md, ack, eo);
    end

    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
